// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared FSM state type and widths for the mul/div scheduler
package muldiv_pkg;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;
  localparam int NLANE = 4;
  localparam int CNT_W = 6;
endpackage

// File: rtl/prio_enc4.sv
// prio_enc4: lowest-index-first priority encoder; req in, valid/idx/one-hot out
module prio_enc4
  import muldiv_pkg::*;
(
  input  logic [NLANE-1:0] req,
  output logic             valid,
  output logic [1:0]       idx,
  output logic [NLANE-1:0] oh
);
  always_comb begin
    valid = |req;
    idx = req[0] ? 2'd0 : req[1] ? 2'd1 : req[2] ? 2'd2 : 2'd3;
    oh = req & (~req + 4'd1);
  end
endmodule

// File: rtl/muldiv_sched.sv
// muldiv_sched: mul/div unit arbiter; lane req/isdiv/signed/rdhilo + stall_ext/kill in, grant/start/hilo_we/busy/stall_lane out
module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NLANE-1:0] req_i,
  input  logic [NLANE-1:0] isdiv_i,
  input  logic [NLANE-1:0] signed_i,
  input  logic [NLANE-1:0] rdhilo_i,
  input  logic             stall_ext_i,
  input  logic             kill_i,
  output logic [NLANE-1:0] grant_o,
  output logic             start_o,
  output logic             start_div_o,
  output logic             start_signed_o,
  output logic             hilo_we_o,
  output logic             busy_o,
  output logic [NLANE-1:0] stall_lane_o
);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic c_v, b_v, go;
  logic [1:0] c_idx, b_idx;
  logic [NLANE-1:0] c_oh, b_oh, older, blocked;
  prio_enc4 u_cand (.req(req_i), .valid(c_v), .idx(c_idx), .oh(c_oh));
  prio_enc4 u_blk (.req(blocked), .valid(b_v), .idx(b_idx), .oh(b_oh));
  always_comb begin
    busy_o = state != IDLE;
    go = !reset && !busy_o && !stall_ext_i && !kill_i && c_v;
    grant_o = go ? c_oh : '0;
    start_o = go;
    start_div_o = go && isdiv_i[c_idx];
    start_signed_o = go && signed_i[c_idx];
    hilo_we_o = busy_o && cnt == '0 && !kill_i && !reset;
  end
  // older[k]: some lane younger-index j<k holds a mult/div ahead of lane k
  always_comb begin
    older = {|req_i[2:0], |req_i[1:0], req_i[0], 1'b0};
    blocked = (req_i & (older | {NLANE{busy_o | stall_ext_i}})) |
              (rdhilo_i & (older | {NLANE{busy_o}}));
  end
  // stall the lowest blocked lane and every lane above it
  always_comb stall_lane_o = b_v ? (b_oh | (4'b1110 << b_idx)) : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else if (busy_o) begin
      if (kill_i || cnt == '0) begin
        state <= IDLE;
        cnt <= '0;
      end else cnt <= cnt - 1'b1;
    end else if (go) begin
      state <= isdiv_i[c_idx] ? DIV : MUL;
      cnt <= isdiv_i[c_idx] ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
    end
  end
endmodule

// File: tb/tb_muldiv_sched.sv
// tb_muldiv_sched: directed and random checks of muldiv_sched against a cycle-time reference model
module tb_muldiv_sched;
  logic clk = 0, reset = 1;
  logic [3:0] req_i = 0, isdiv_i = 0, signed_i = 0, rdhilo_i = 0;
  logic stall_ext_i = 0, kill_i = 0;
  logic [3:0] grant[2], stall[2];
  logic start[2], sdiv[2], ssig[2], hw[2], busy[2];
  logic [3:0] cg[2], cs[2];
  logic cst[2], csd[2], csg[2], chw[2], cb[2];
  int total = 0, bad = 0, now = 0, n = 0;
  bit en = 0;
  bit act[2];
  int done[2];
  always #5 clk = ~clk;
  muldiv_sched #(.MUL_LAT(3), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .req_i(req_i), .isdiv_i(isdiv_i), .signed_i(signed_i),
    .rdhilo_i(rdhilo_i), .stall_ext_i(stall_ext_i), .kill_i(kill_i), .grant_o(grant[0]),
    .start_o(start[0]), .start_div_o(sdiv[0]), .start_signed_o(ssig[0]), .hilo_we_o(hw[0]),
    .busy_o(busy[0]), .stall_lane_o(stall[0]));
  muldiv_sched #(.MUL_LAT(1), .DIV_LAT(2)) dut1 (
    .clk(clk), .reset(reset), .req_i(req_i), .isdiv_i(isdiv_i), .signed_i(signed_i),
    .rdhilo_i(rdhilo_i), .stall_ext_i(stall_ext_i), .kill_i(kill_i), .grant_o(grant[1]),
    .start_o(start[1]), .start_div_o(sdiv[1]), .start_signed_o(ssig[1]), .hilo_we_o(hw[1]),
    .busy_o(busy[1]), .stall_lane_o(stall[1]));
  function automatic int lat(input int m, input logic dv);
    return dv ? (m == 1 ? 2 : 32) : (m == 1 ? 1 : 3);
  endfunction
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cyc=%0d", nm, a, e, now);
    end
  endtask
  // one cycle: drive, sample mid-cycle, compare both instances to the model, advance
  task automatic cyc(input logic [3:0] rq, dv, sg, rd, input logic se, kl, rs);
    req_i = rq; isdiv_i = dv; signed_i = sg; rdhilo_i = rd;
    stall_ext_i = se; kill_i = kl; reset = rs;
    assert ((rq & rd) == 4'b0) else $error("req and rdhilo overlap in one lane");
    #3;
    for (int m = 0; m < 2; m++) begin
      int c, b;
      logic go, ehw, ed, eg_s, older;
      logic [3:0] eg, es;
      c = -1; b = -1; es = 0; ed = 0; eg_s = 0;
      for (int k = 0; k < 4; k++) if (rq[k] && c < 0) c = k;
      go = !rs && !act[m] && !se && !kl && c >= 0;
      eg = go ? 4'(1 << c) : 4'b0;
      if (go) begin ed = dv[c]; eg_s = sg[c]; end
      ehw = act[m] && now == done[m] && !kl && !rs;
      for (int k = 0; k < 4; k++) begin
        older = (rq & 4'((1 << k) - 1)) != 0;
        if (b < 0 && ((rq[k] && (act[m] || older || se)) || (rd[k] && (act[m] || older)))) b = k;
      end
      if (b >= 0) for (int k = 0; k < 4; k++) if (k >= b) es[k] = 1'b1;
      cg[m] = grant[m]; cs[m] = stall[m]; cst[m] = start[m]; csd[m] = sdiv[m];
      csg[m] = ssig[m]; chw[m] = hw[m]; cb[m] = busy[m];
      if (en) begin
        chk($sformatf("grant%0d", m), grant[m], eg);
        chk($sformatf("start%0d", m), start[m], go);
        chk($sformatf("start_div%0d", m), sdiv[m], ed);
        chk($sformatf("start_signed%0d", m), ssig[m], eg_s);
        chk($sformatf("hilo_we%0d", m), hw[m], ehw);
        chk($sformatf("busy%0d", m), busy[m], act[m]);
        chk($sformatf("stall%0d", m), stall[m], es);
      end
      if (rs) act[m] = 0;
      else if (act[m] && (kl || now == done[m])) act[m] = 0;
      else if (go) begin act[m] = 1; done[m] = now + lat(m, dv[c]); end
    end
    now++;
    @(posedge clk); #1;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    @(posedge clk); #1;
    cyc(0, 0, 0, 0, 0, 0, 1);
    en = 1;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("rst_busy", cb[0], 0); chk("rst_grant", cg[0], 0);
    chk("rst_hw", chw[0], 0); chk("rst_stall", cs[0], 0);
    cyc(4'b0100, 0, 4'b0100, 0, 0, 0, 0);
    chk("mul_grant", cg[0], 4'b0100); chk("mul_start", cst[0], 1);
    chk("mul_signed", csg[0], 1); chk("mul_div", csd[0], 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("mul_t1_busy", cb[0], 1); chk("mul_t1_hw", chw[0], 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("mul_t2_hw", chw[0], 0);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("mul_t3_hw", chw[0], 1); chk("mul_t3_busy", cb[0], 1);
    cyc(0, 0, 0, 0, 0, 0, 0); chk("mul_t4_busy", cb[0], 0); chk("mul_t4_hw", chw[0], 0);
    idle(4);
    cyc(4'b0011, 4'b0001, 0, 0, 0, 0, 0);
    chk("cont_grant", cg[0], 4'b0001); chk("cont_stall", cs[0], 4'b1110); chk("cont_div", csd[0], 1);
    n = 0;
    for (int i = 1; i <= 32; i++) begin
      cyc(4'b0010, 0, 0, 0, 0, 0, 0);
      if (cs[0] == 4'b1110 && cg[0] == 0) n++;
      if (i == 32) chk("cont_hw_t32", chw[0], 1);
    end
    chk("cont_stalled_cycles", n, 32);
    cyc(4'b0010, 0, 0, 0, 0, 0, 0); chk("cont_grant2", cg[0], 4'b0010);
    idle(6);
    cyc(4'b0001, 4'b0001, 0, 0, 0, 0, 0); chk("rd_grant", cg[0], 4'b0001);
    n = 0;
    for (int i = 1; i <= 32; i++) begin
      cyc(0, 0, 0, 4'b0001, 0, 0, 0);
      if (cs[0] == 4'b1111) n++;
      if (i == 32) chk("rd_hw_t32", chw[0], 1);
    end
    chk("rd_stalled_cycles", n, 32);
    cyc(0, 0, 0, 4'b0001, 0, 0, 0); chk("rd_t33_stall", cs[0], 0);
    idle(3);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0001, 0, 0, 0, 1, 0, 0);
      chk("hold_grant", cg[0], 0); chk("hold_start", cst[0], 0); chk("hold_stall", cs[0], 4'b1111);
    end
    cyc(4'b0001, 0, 0, 0, 0, 0, 0); chk("hold_release_grant", cg[0], 4'b0001);
    idle(5);
    cyc(4'b0001, 4'b0001, 0, 0, 0, 0, 0);
    idle(9);
    cyc(0, 0, 0, 0, 0, 1, 0); chk("kill_hw", chw[0], 0);
    n = 0;
    for (int i = 11; i <= 40; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (i == 11) chk("kill_t11_busy", cb[0], 0);
      n += chw[0];
    end
    chk("kill_no_hw", n, 0);
    cyc(4'b0001, 4'b0001, 0, 0, 0, 0, 0);
    idle(9);
    cyc(0, 0, 0, 0, 0, 0, 1);
    n = 0;
    for (int i = 11; i <= 40; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0);
      if (i == 11)
        chk("rst_mid_outs", {cg[0], cst[0], csd[0], csg[0], chw[0], cb[0], cs[0]}, 0);
      n += chw[0];
    end
    chk("rst_mid_no_hw", n, 0);
    cyc(4'b0001, 0, 0, 0, 0, 0, 0); chk("lat1_t0_grant", cg[1], 4'b0001);
    cyc(4'b0001, 0, 0, 0, 0, 0, 0); chk("lat1_t1_hw", chw[1], 1); chk("lat1_t1_grant", cg[1], 0);
    cyc(4'b0001, 0, 0, 0, 0, 0, 0); chk("lat1_t2_grant", cg[1], 4'b0001);
    idle(6);
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] rq, rd;
      rq = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      rd = ($urandom_range(0, 1) == 0) ? (4'($urandom) & ~rq) : 4'b0;
      cyc(rq, 4'($urandom), 4'($urandom), rd, $urandom_range(0, 9) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 59) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
